// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared state encoding and frame constants for the UART boot loader
package boot_loader_pkg;

  typedef enum logic [3:0] {
    ST_HUNT,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Word bytes arrive little-endian: B0 lands in bits 7:0, B2 in bits 23:16.
  localparam int WORD_BYTES  = 3;
  localparam int WORD_B0_LSB = 0;
  localparam int WORD_B1_LSB = 8;
  localparam int WORD_B2_LSB = 16;

  // States inside a frame, where the inter-byte idle timeout is running.
  // WRITE is excluded so the sram cycle never eats into the byte budget.
  function automatic logic is_timed_state(state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_B0) ||
           (s == ST_B1) || (s == ST_B2) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_timeout_cnt.sv
// rtl/boot_timeout_cnt.sv - loadable saturating down-counter for boot window and byte timeout
module boot_timeout_cnt #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; decrement stops at zero so expiry is sticky until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART image loader that owns sram port A while the CPU is held
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 13,
  parameter int         INSN_WIDTH   = 18,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         BOOT_WAIT    = 1000000,
  parameter int         BYTE_TIMEOUT = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_d_valid,
  input  logic [7:0]            rx_rdata,
  output logic                  rx_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INSN_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [16:0] DEPTH       = 17'(1) << ADDR_WIDTH;
  localparam logic [31:0] WAIT_VAL    = 32'(BOOT_WAIT);
  localparam logic [31:0] TIMEOUT_VAL = 32'(BYTE_TIMEOUT);

  state_t                state;
  logic                  gap;
  logic                  started;
  logic [7:0]            cnt_lo;
  logic [7:0]            byte0;
  logic [7:0]            byte1;
  logic [7:0]            csum;
  logic [16:0]           remaining;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [15:0]           count_word;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_expired;

  assign count_word = {rx_rdata, cnt_lo};

  // One counter serves both the power-up window (HUNT before any sync) and the in-frame idle timeout.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (rx_rd && ((state != ST_HUNT) || (rx_rdata == SYNC_BYTE))) begin
      tmr_load = 1'b1;
    end
    if (((state == ST_HUNT) && !started) || is_timed_state(state)) begin
      tmr_dec = 1'b1;
    end
  end

  boot_timeout_cnt #(
    .WIDTH     (32),
    .RESET_VAL (WAIT_VAL)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TIMEOUT_VAL),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  // Loader FSM: a byte is captured on the cycle rx_rd is high, then one cycle is skipped before the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      rx_rd     <= 1'b0;
      gap       <= 1'b0;
      started   <= 1'b0;
      cnt_lo    <= '0;
      byte0     <= '0;
      byte1     <= '0;
      csum      <= '0;
      remaining <= '0;
      word_addr <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      rx_rd  <= 1'b0;
      gap    <= rx_rd;
      case (state)
        ST_WRITE: begin
          word_addr <= word_addr + ADDR_WIDTH'(1);
          remaining <= remaining - 17'd1;
          state     <= (remaining == 17'd1) ? ST_CSUM : ST_B0;
        end
        ST_ERR: begin
          state <= ST_HUNT;
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          if (rx_rd) begin
            case (state)
              ST_HUNT: begin
                if (rx_rdata == SYNC_BYTE) begin
                  load_err  <= 1'b0;
                  load_done <= 1'b0;
                  csum      <= '0;
                  started   <= 1'b1;
                  state     <= ST_CNT_LO;
                end
              end
              ST_CNT_LO: begin
                cnt_lo <= rx_rdata;
                csum   <= csum + rx_rdata;
                state  <= ST_CNT_HI;
              end
              ST_CNT_HI: begin
                csum <= csum + rx_rdata;
                if ((count_word == 16'd0) || ({1'b0, count_word} > DEPTH)) begin
                  load_err <= 1'b1;
                  state    <= ST_ERR;
                end else begin
                  remaining <= {1'b0, count_word};
                  word_addr <= '0;
                  state     <= ST_B0;
                end
              end
              ST_B0: begin
                byte0 <= rx_rdata;
                csum  <= csum + rx_rdata;
                state <= ST_B1;
              end
              ST_B1: begin
                byte1 <= rx_rdata;
                csum  <= csum + rx_rdata;
                state <= ST_B2;
              end
              ST_B2: begin
                // High bits of B2 beyond the sram width fall off in the cast.
                csum      <= csum + rx_rdata;
                mem_wr    <= 1'b1;
                mem_addr  <= word_addr;
                mem_wdata <= INSN_WIDTH'({rx_rdata, byte1, byte0});
                state     <= ST_WRITE;
              end
              ST_CSUM: begin
                if (rx_rdata == csum) begin
                  load_done <= 1'b1;
                  cpu_hold  <= 1'b0;
                  state     <= ST_RUN;
                end else begin
                  load_err <= 1'b1;
                  state    <= ST_ERR;
                end
              end
              default: begin
                state <= ST_ERR;
              end
            endcase
          end else if (tmr_expired && ((state != ST_HUNT) || !started)) begin
            if (state == ST_HUNT) begin
              cpu_hold <= 1'b0;
              state    <= ST_RUN;
            end else begin
              load_err <= 1'b1;
              state    <= ST_ERR;
            end
          end else if (rx_d_valid && !gap) begin
            rx_rd <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed table-driven bench for uart_boot_loader
module tb_uart_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_d_valid;
  logic [7:0]  rx_rdata;
  logic        rx_rd;
  logic [12:0] mem_addr;
  logic [17:0] mem_wdata;
  logic        mem_wr;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  uart_boot_loader #(
    .ADDR_WIDTH   (13),
    .INSN_WIDTH   (18),
    .SYNC_BYTE    (8'hA5),
    .BOOT_WAIT    (100),
    .BYTE_TIMEOUT (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_d_valid (rx_d_valid),
    .rx_rdata   (rx_rdata),
    .rx_rd      (rx_rd),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int          pop_total = 0;
  int          wr_total  = 0;
  int          rd_viol   = 0;
  int          wr_viol   = 0;
  logic        prev_rd   = 1'b0;
  logic [12:0] wr_addr_log [64];
  logic [17:0] wr_data_log [64];

  // Passive monitor sampling on the falling edge.
  always @(negedge clk) begin
    prev_rd <= rx_rd;
    if (rx_rd) pop_total <= pop_total + 1;
    if (rx_rd && prev_rd) rd_viol <= rd_viol + 1;
    if (mem_wr) begin
      wr_addr_log[wr_total % 64] <= mem_addr;
      wr_data_log[wr_total % 64] <= mem_wdata;
      wr_total <= wr_total + 1;
      if (!cpu_hold) wr_viol <= wr_viol + 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit popped);
    popped     = 1'b0;
    rx_rdata   = b;
    rx_d_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_rd) begin
        popped = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_d_valid = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  task automatic send_frame(input logic [95:0] fr, input int first, input int n);
    bit p;
    for (int i = first; i < n; i++) begin
      send_byte(fr[95 - 8*i -: 8], p);
      check($sformatf("pop_byte%0d", i), p, 1);
    end
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [95:0] bytes;
    bit          exp_done;
    bit          exp_err;
    bit          exp_hold;
    int          exp_wr;
    logic [17:0] d0;
    logic [17:0] d1;
  } vec_t;

  localparam logic [95:0] GOOD = 96'hA5_02_00_45_23_01_FF_FF_03_6C_00_00;
  localparam logic [95:0] BAD  = 96'hA5_02_00_45_23_01_FF_FF_03_6D_00_00;

  vec_t vecs [5];

  initial begin
    int  cyc;
    int  base_wr;
    int  base_pop;
    bit  p;

    vecs[0] = '{"good_frame", 10, GOOD, 1'b1, 1'b0, 1'b0, 2, 18'h12345, 18'h3FFFF};
    vecs[1] = '{"bad_csum",   10, BAD,  1'b0, 1'b1, 1'b1, 2, 18'h12345, 18'h3FFFF};
    vecs[2] = '{"count_zero",  3, 96'hA5_00_00_000000000000000000, 1'b0, 1'b1, 1'b1, 0, 18'h0, 18'h0};
    vecs[3] = '{"count_big",   3, 96'hA5_01_20_000000000000000000, 1'b0, 1'b1, 1'b1, 0, 18'h0, 18'h0};
    vecs[4] = '{"garbage_b2ff", 10, 96'h00_5A_33_A5_01_00_EF_BE_FF_AD_00_00, 1'b1, 1'b0, 1'b0, 1, 18'h3BEEF, 18'h0};

    rst_n      = 1'b0;
    rx_d_valid = 1'b0;
    rx_rdata   = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_cpu_hold",  cpu_hold,  1);
    check("rst_load_done", load_done, 0);
    check("rst_load_err",  load_err,  0);
    check("rst_rx_rd",     rx_rd,     0);
    check("rst_mem_wr",    mem_wr,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);

    // Boot window expiry with no input.
    @(negedge clk);
    rst_n   = 1'b1;
    base_wr = wr_total;
    cyc     = 0;
    while (cpu_hold && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    vectors++;
    if (cyc < 100 || cyc > 102) begin
      miscompares++;
      $display("FAIL boot_window: hold fell after %0d cycles, required 100..102", cyc);
    end
    check("window_done", load_done, 0);
    check("window_err",  load_err,  0);
    @(negedge clk);
    check("window_no_wr", wr_total - base_wr, 0);

    // Table of whole frames, each from a fresh reset.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      base_wr  = wr_total;
      base_pop = pop_total;
      send_frame(vecs[v].bytes, 0, vecs[v].n);
      repeat (3) @(negedge clk);
      check({vecs[v].name, "_done"}, load_done, vecs[v].exp_done);
      check({vecs[v].name, "_err"},  load_err,  vecs[v].exp_err);
      check({vecs[v].name, "_hold"}, cpu_hold,  vecs[v].exp_hold);
      check({vecs[v].name, "_nwr"},  wr_total - base_wr,  vecs[v].exp_wr);
      check({vecs[v].name, "_pops"}, pop_total - base_pop, vecs[v].n);
      if (wr_total - base_wr >= 1) begin
        check({vecs[v].name, "_a0"}, wr_addr_log[base_wr % 64], 0);
        check({vecs[v].name, "_d0"}, wr_data_log[base_wr % 64], vecs[v].d0);
      end
      if (wr_total - base_wr >= 2) begin
        check({vecs[v].name, "_a1"}, wr_addr_log[(base_wr + 1) % 64], 1);
        check({vecs[v].name, "_d1"}, wr_data_log[(base_wr + 1) % 64], vecs[v].d1);
      end
    end

    // Bad checksum, then recovery by resending the good frame.
    do_reset();
    send_frame(BAD, 0, 10);
    repeat (2) @(negedge clk);
    check("recover_err_set", load_err, 1);
    send_frame(GOOD, 0, 1);
    check("recover_err_clr_on_sync", load_err, 0);
    base_wr = wr_total;
    send_frame(GOOD, 1, 10);
    repeat (2) @(negedge clk);
    check("recover_done", load_done, 1);
    check("recover_hold", cpu_hold,  0);
    check("recover_nwr",  wr_total - base_wr, 2);
    send_byte(8'h55, p);
    check("run_no_pop", p, 0);

    // Mid-frame silence hits the byte timeout, then the window stays disabled.
    do_reset();
    base_wr = wr_total;
    send_frame(96'hA5_01_00_11_22_00000000000000, 0, 5);
    check("timeout_not_early", load_err, 0);
    repeat (50) @(negedge clk);
    check("timeout_err",   load_err, 1);
    check("timeout_no_wr", wr_total - base_wr, 0);
    repeat (120) @(negedge clk);
    check("window_disabled_hold", cpu_hold, 1);

    // Asynchronous reset in the middle of a frame after one word was written.
    base_wr = wr_total;
    send_frame(GOOD, 0, 7);
    check("midframe_one_wr", wr_total - base_wr, 1);
    check("midframe_addr_before", mem_addr, 0);
    check("midframe_data_before", mem_wdata, 18'h12345);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_hold",  cpu_hold,  1);
    check("areset_done",  load_done, 0);
    check("areset_err",   load_err,  0);
    check("areset_rd",    rx_rd,     0);
    check("areset_wr",    mem_wr,    0);
    check("areset_wdata", mem_wdata, 0);
    base_wr = wr_total;
    repeat (20) @(negedge clk);
    check("areset_no_wr", wr_total - base_wr, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("rd_back_to_back", rd_viol, 0);
    check("wr_while_released", wr_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
